housekeeping_spi: RTL and testbench
===================================

# housekeeping_spi

Housekeeping SPI slave for the chip's management area. An external host on the housekeeping pins can read and write a small register file, including the product ID and the CPU reset control. It can also switch the port into a pass-thru mode that connects the host directly to the user-area SPI flash or the management SPI flash. The SPI pins are oversampled by the single system clock; only the pass-thru data path is combinational.

## Interface
- PRODUCT_ID, 8'h20, value returned at register 0x03
- MFG_ID, 12'h456, manufacturer ID; reg 0x01 = {4'h0, MFG_ID[11:8]}, reg 0x02 = MFG_ID[7:0]
- PROJECT_ID, 32'h0, regs 0x04..0x07, MSB first
- clock  in  1  system clock; one clock domain
- resetb  in  1  synchronous, active-low reset
- spi_csb  in  1  host chip select, active low
- spi_sck  in  1  host SPI clock, mode 0
- spi_sdi  in  1  host data in
- spi_sdo  out  1  host data out
- spi_sdo_oe  out  1  1 while the block drives spi_sdo
- user_flash_csb / user_flash_sck / user_flash_io0  out  1 each  user flash CS, clock, MOSI
- user_flash_io1  in  1  user flash MISO
- mgmt_flash_csb / mgmt_flash_sck / mgmt_flash_io0  out  1 each  management flash override pins
- mgmt_flash_io1  in  1  management flash MISO
- pass_thru_user / pass_thru_mgmt  out  1 each  pass-thru mode active
- cpu_reset  out  1  held high to reset the management CPU

## Operation
- **Synchronisation:** spi_csb, spi_sck and spi_sdi pass through 2-FF synchronisers. SCK rising and falling edges are detected on the synchronised value.
- **Transaction start:** a synchronised CSB fall starts a transaction in state CMD with the bit counter at 0.
- **Transaction abort:** a synchronised CSB high at any time returns to IDLE. Any partial byte is discarded. Pass-thru flags clear.
- **Bit order:** bits are shifted in MSB first on each detected SCK rise. A byte completes at the 8th rise.
- **Commands (first byte):**
  - 0x40 read stream: next byte is ADDR, then DATA bytes are shifted out.
  - 0x80 write stream: ADDR, then each received DATA byte is written to reg[addr].
  - 0xC0 read/write stream: each byte shifts out the old reg[addr] while writing the new value.
  - 0xC2: user pass-thru.
  - 0xC4: management pass-thru.
  - Any other value: ignore all bits until CSB rises.
- **Stream addressing:** addr increments by 1 after each DATA byte. It is 8-bit and wraps 0xFF to 0x00.
- **Register map:**
  - 0x00 status, reads 0.
  - 0x01/0x02 manufacturer ID; 0x03 PRODUCT_ID; 0x04..0x07 PROJECT_ID. All read-only.
  - 0x0B bit0 is cpu_reset (R/W); other bits read 0.
  - Unmapped addresses read 0x00 and ignore writes.
- **Read output:** in read states, spi_sdo carries MSB-first data. The next bit is loaded after each detected SCK rise. The first data bit is loaded after the 8th rise of the ADDR byte.
- **spi_sdo_oe:** 1 only while in read DATA or a pass-thru state, otherwise 0 (spi_sdo = 0).
- **User pass-thru:** a registered flag is set after the 8th rise of 0xC2 and held until CSB rises. While the flag is set:
  - user_flash_csb = spi_csb, user_flash_sck = spi_sck, user_flash_io0 = spi_sdi, combinational from the raw pins.
  - spi_sdo = user_flash_io1.
  - Otherwise user_flash_csb = 1 and user_flash_sck = user_flash_io0 = 0.
- **Management pass-thru:** identical routing onto the mgmt_flash_* pins. While pass_thru_mgmt is set, cpu_reset is forced to 1. When the mode ends, cpu_reset returns to the register 0x0B bit0 value.
- **Reset (resetb low):** state IDLE, all counters and flags clear, reg 0x0B = 0, cpu_reset = 0, spi_sdo = 0, spi_sdo_oe = 0, flash csb outputs = 1, flash sck/io0 outputs = 0. A reset asserted mid-transaction aborts it; the block waits for a fresh CSB fall.

## Timing
- SCK high and low phases are each ≥ 4 clock periods. CSB setup before the first SCK rise is ≥ 2 periods.
- Edge detection latency is 2–3 clocks.
- spi_sdo changes no later than 4 clocks after an SCK rise and stays stable until the next rise.
- A register write takes effect (cpu_reset visible) within 4 clocks of the 8th rise of the data byte.
- The pass-thru flag is set within 4 clocks of the 8th command rise, before the next SCK rise. Pass-thru routing itself has no clock latency.
- CSB rise ends pass-thru combinationally on the csb outputs; the flags clear within 3 clocks.

## Test plan
- CSB low, 0x40, 0x03, read one byte, CSB high -> 0x20; 0x40, 0x01, read 2 bytes -> 0x04, 0x56.
- 0x80, 0x0B, 0x01 -> cpu_reset = 1; then 0x80, 0x0B, 0x00 -> cpu_reset = 0. 0x40, 0x0B reads back each value.
- 0xC2, 0x03, 0x00, 0x00, 0x00, then read 8 bytes with flash model preloaded 6F 00 00 0B 93 01 00 00 -> identical bytes on spi_sdo; user_flash_csb low only after the 0xC2 byte.
- 0xC4 pass-thru -> cpu_reset high during the transfer, mgmt_flash pins follow the host; CSB high -> cpu_reset back to the register value.
- Command 0x13, or CSB raised after 5 bits of 0x80 -> no register change, spi_sdo_oe = 0.
- resetb low mid-read-stream -> outputs at reset values; a following 0x40/0x03 read returns 0x20.

Source files
------------

// File: rtl/housekeeping_spi_if.sv
// rtl/housekeeping_spi_if.sv - host-side housekeeping SPI pins
interface housekeeping_spi_if;
    logic spi_csb;
    logic spi_sck;
    logic spi_sdi;
    logic spi_sdo;
    logic spi_sdo_oe;

    modport master (output spi_csb, spi_sck, spi_sdi, input spi_sdo, spi_sdo_oe);
    modport slave  (input spi_csb, spi_sck, spi_sdi, output spi_sdo, spi_sdo_oe);
endinterface

// File: rtl/housekeeping_spi.sv
// rtl/housekeeping_spi.sv - oversampled housekeeping SPI slave with register file and flash pass-thru
module housekeeping_spi #(
    parameter logic [7:0]  PRODUCT_ID = 8'h20,
    parameter logic [11:0] MFG_ID     = 12'h456,
    parameter logic [31:0] PROJECT_ID = 32'h0
) (
    input  logic                  clock,
    input  logic                  resetb,
    housekeeping_spi_if.slave     host,
    output logic                  user_flash_csb,
    output logic                  user_flash_sck,
    output logic                  user_flash_io0,
    input  logic                  user_flash_io1,
    output logic                  mgmt_flash_csb,
    output logic                  mgmt_flash_sck,
    output logic                  mgmt_flash_io0,
    input  logic                  mgmt_flash_io1,
    output logic                  pass_thru_user,
    output logic                  pass_thru_mgmt,
    output logic                  cpu_reset
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, PASS_USER, PASS_MGMT, IGNORE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  csb_sync;
    logic        csb_q;
    logic [2:0]  sck_sync;
    logic [1:0]  sdi_sync;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic [7:0]  addr_q;
    logic [7:0]  sdo_q;
    logic        rd_q;
    logic        wr_q;
    logic        cpu_reset_q;

    logic        csb_s;
    logic        csb_fall;
    logic        sck_rise;
    logic [7:0]  byte_in;
    logic        byte_done;
    logic        read_data;

    function automatic logic [7:0] reg_read(input logic [7:0] a, input logic rst_bit);
        case (a)
            8'h01:   reg_read = {4'h0, MFG_ID[11:8]};
            8'h02:   reg_read = MFG_ID[7:0];
            8'h03:   reg_read = PRODUCT_ID;
            8'h04:   reg_read = PROJECT_ID[31:24];
            8'h05:   reg_read = PROJECT_ID[23:16];
            8'h06:   reg_read = PROJECT_ID[15:8];
            8'h07:   reg_read = PROJECT_ID[7:0];
            8'h0B:   reg_read = {7'h0, rst_bit};
            default: reg_read = 8'h00;
        endcase
    endfunction

    // CSB synchroniser resets low so a CSB already held low at reset release is not seen as a fall.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            csb_sync <= 2'b00;
            csb_q    <= 1'b0;
            sck_sync <= 3'b000;
            sdi_sync <= 2'b00;
        end else begin
            csb_sync <= {csb_sync[0], host.spi_csb};
            csb_q    <= csb_sync[1];
            sck_sync <= {sck_sync[1:0], host.spi_sck};
            sdi_sync <= {sdi_sync[0], host.spi_sdi};
        end
    end

    assign csb_s     = csb_sync[1];
    assign csb_fall  = csb_q & ~csb_s;
    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign byte_in   = {shift_q, sdi_sync[1]};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign read_data = (state_q == DATA) && rd_q;

    always_ff @(posedge clock) begin
        if (!resetb) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (csb_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (csb_fall) state_d = CMD;
                CMD: if (byte_done) begin
                    case (byte_in)
                        8'h40, 8'h80, 8'hC0: state_d = ADDR;
                        8'hC2:               state_d = PASS_USER;
                        8'hC4:               state_d = PASS_MGMT;
                        default:             state_d = IGNORE;
                    endcase
                end
                ADDR: if (byte_done) state_d = DATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Command bit7 selects write, bit6 selects read; only meaningful for 0x40/0x80/0xC0.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            bit_cnt     <= 3'd0;
            shift_q     <= 7'd0;
            addr_q      <= 8'd0;
            sdo_q       <= 8'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cpu_reset_q <= 1'b0;
        end else if (csb_s) begin
            bit_cnt <= 3'd0;
            sdo_q   <= 8'd0;
        end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift_q <= byte_in[6:0];
            case (state_q)
                CMD: if (bit_cnt == 3'd7) begin
                    rd_q <= byte_in[6];
                    wr_q <= byte_in[7];
                end
                ADDR: if (bit_cnt == 3'd7) begin
                    addr_q <= byte_in;
                    sdo_q  <= reg_read(byte_in, cpu_reset_q);
                end
                DATA: if (bit_cnt == 3'd7) begin
                    if (wr_q && addr_q == 8'h0B) cpu_reset_q <= byte_in[0];
                    addr_q <= addr_q + 8'd1;
                    sdo_q  <= reg_read(addr_q + 8'd1, cpu_reset_q);
                end else begin
                    sdo_q <= {sdo_q[6:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    // Pass-thru routing is deliberately combinational from the raw pins.
    always_comb begin
        pass_thru_user  = (state_q == PASS_USER);
        pass_thru_mgmt  = (state_q == PASS_MGMT);
        user_flash_csb  = pass_thru_user ? host.spi_csb : 1'b1;
        user_flash_sck  = pass_thru_user ? host.spi_sck : 1'b0;
        user_flash_io0  = pass_thru_user ? host.spi_sdi : 1'b0;
        mgmt_flash_csb  = pass_thru_mgmt ? host.spi_csb : 1'b1;
        mgmt_flash_sck  = pass_thru_mgmt ? host.spi_sck : 1'b0;
        mgmt_flash_io0  = pass_thru_mgmt ? host.spi_sdi : 1'b0;
        host.spi_sdo_oe = read_data | pass_thru_user | pass_thru_mgmt;
        host.spi_sdo    = 1'b0;
        if (pass_thru_user)      host.spi_sdo = user_flash_io1;
        else if (pass_thru_mgmt) host.spi_sdo = mgmt_flash_io1;
        else if (read_data)      host.spi_sdo = sdo_q[7];
        cpu_reset       = cpu_reset_q | pass_thru_mgmt;
    end

endmodule

// File: tb/tb_housekeeping_spi.sv
// tb/tb_housekeeping_spi.sv - directed self-checking bench for housekeeping_spi
module tb_housekeeping_spi;
    logic clock = 1'b0;
    logic resetb = 1'b0;
    logic user_flash_csb, user_flash_sck, user_flash_io0;
    logic user_flash_io1 = 1'b0;
    logic mgmt_flash_csb, mgmt_flash_sck, mgmt_flash_io0;
    logic mgmt_flash_io1 = 1'b0;
    logic pass_thru_user, pass_thru_mgmt, cpu_reset;

    int n_checks = 0;
    int n_pass = 0;

    housekeeping_spi_if hif ();

    housekeeping_spi dut (
        .clock          (clock),
        .resetb         (resetb),
        .host           (hif),
        .user_flash_csb (user_flash_csb),
        .user_flash_sck (user_flash_sck),
        .user_flash_io0 (user_flash_io0),
        .user_flash_io1 (user_flash_io1),
        .mgmt_flash_csb (mgmt_flash_csb),
        .mgmt_flash_sck (mgmt_flash_sck),
        .mgmt_flash_io0 (mgmt_flash_io0),
        .mgmt_flash_io1 (mgmt_flash_io1),
        .pass_thru_user (pass_thru_user),
        .pass_thru_mgmt (pass_thru_mgmt),
        .cpu_reset      (cpu_reset)
    );

    always #5 clock = ~clock;

    // User flash model: answers a 0x03 read with a fixed image, data changing on SCK fall.
    logic [7:0] fl_mem [8] = '{8'h6F, 8'h00, 8'h00, 8'h0B, 8'h93, 8'h01, 8'h00, 8'h00};
    logic       fs_sck = 1'b0;
    logic       fs_csb = 1'b1;
    int         fl_bits = 0;
    logic [7:0] fl_cmd = 8'h00;

    always @(posedge clock) begin
        fs_sck <= user_flash_sck;
        fs_csb <= user_flash_csb;
        if (user_flash_csb) begin
            fl_bits <= 0;
        end else if (!fs_csb && user_flash_sck && !fs_sck) begin
            if (fl_bits < 8) fl_cmd <= {fl_cmd[6:0], user_flash_io0};
            fl_bits <= fl_bits + 1;
        end else if (!fs_csb && !user_flash_sck && fs_sck && fl_bits >= 32 && fl_bits < 96) begin
            user_flash_io1 <= fl_mem[(fl_bits - 32) / 8][7 - ((fl_bits - 32) % 8)];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cs_low();
        hif.spi_csb = 1'b0;
        clocks(4);
    endtask

    task automatic cs_high();
        hif.spi_sck = 1'b0;
        hif.spi_csb = 1'b1;
        clocks(8);
    endtask

    task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            hif.spi_sdi = tx[i];
            clocks(6);
            rx[i] = hif.spi_sdo;
            hif.spi_sck = 1'b1;
            clocks(6);
            hif.spi_sck = 1'b0;
        end
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
        logic [7:0] r;
        cs_low();
        xfer(8'h40, 8, r);
        xfer(a, 8, r);
        xfer(8'h00, 8, d);
        cs_high();
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        cs_low();
        xfer(8'h80, 8, r);
        xfer(a, 8, r);
        xfer(d, 8, r);
        cs_high();
    endtask

    initial begin
        logic [7:0] r;
        hif.spi_csb = 1'b1;
        hif.spi_sck = 1'b0;
        hif.spi_sdi = 1'b0;
        clocks(5);
        check("rst_sdo_oe", hif.spi_sdo_oe, 0);
        check("rst_sdo", hif.spi_sdo, 0);
        check("rst_cpu_reset", cpu_reset, 0);
        check("rst_user_csb", user_flash_csb, 1);
        check("rst_mgmt_csb", mgmt_flash_csb, 1);
        resetb = 1'b1;
        clocks(5);

        read_reg(8'h03, r);
        check("rd_product_id", r, 8'h20);

        cs_low();
        xfer(8'h40, 8, r);
        xfer(8'h01, 8, r);
        check("rd_oe_in_data", hif.spi_sdo_oe, 1);
        xfer(8'h00, 8, r);
        check("rd_mfg_hi", r, 8'h04);
        xfer(8'h00, 8, r);
        check("rd_mfg_lo", r, 8'h56);
        cs_high();
        check("oe_after_csb", hif.spi_sdo_oe, 0);

        write_reg(8'h0B, 8'h01);
        check("wr_cpu_reset_1", cpu_reset, 1);
        read_reg(8'h0B, r);
        check("rd_cpu_reset_1", r, 8'h01);
        write_reg(8'h0B, 8'h00);
        check("wr_cpu_reset_0", cpu_reset, 0);
        read_reg(8'h0B, r);
        check("rd_cpu_reset_0", r, 8'h00);

        cs_low();
        check("user_csb_before_cmd", user_flash_csb, 1);
        xfer(8'hC2, 8, r);
        check("pass_user_flag", pass_thru_user, 1);
        check("user_csb_after_cmd", user_flash_csb, 0);
        xfer(8'h03, 8, r);
        xfer(8'h00, 8, r);
        xfer(8'h00, 8, r);
        xfer(8'h00, 8, r);
        check("flash_cmd_seen", fl_cmd, 8'h03);
        for (int k = 0; k < 8; k++) begin
            xfer(8'h00, 8, r);
            check($sformatf("flash_byte%0d", k), r, fl_mem[k]);
        end
        check("pass_user_oe", hif.spi_sdo_oe, 1);
        hif.spi_csb = 1'b1;
        #1;
        check("user_csb_comb_release", user_flash_csb, 1);
        clocks(6);
        check("pass_user_cleared", pass_thru_user, 0);

        cs_low();
        xfer(8'hC4, 8, r);
        check("pass_mgmt_flag", pass_thru_mgmt, 1);
        check("mgmt_cpu_reset", cpu_reset, 1);
        check("mgmt_csb_follow", mgmt_flash_csb, 0);
        hif.spi_sck = 1'b1;
        hif.spi_sdi = 1'b1;
        #1;
        check("mgmt_sck_follow", mgmt_flash_sck, 1);
        check("mgmt_io0_follow", mgmt_flash_io0, 1);
        mgmt_flash_io1 = 1'b1;
        #1;
        check("mgmt_sdo_1", hif.spi_sdo, 1);
        mgmt_flash_io1 = 1'b0;
        #1;
        check("mgmt_sdo_0", hif.spi_sdo, 0);
        clocks(6);
        hif.spi_sck = 1'b0;
        hif.spi_sdi = 1'b0;
        clocks(6);
        hif.spi_csb = 1'b1;
        #1;
        check("mgmt_csb_comb_release", mgmt_flash_csb, 1);
        clocks(6);
        check("mgmt_cpu_reset_restored", cpu_reset, 0);
        check("pass_mgmt_cleared", pass_thru_mgmt, 0);

        cs_low();
        xfer(8'h13, 8, r);
        xfer(8'h0B, 8, r);
        xfer(8'h01, 8, r);
        check("bad_cmd_oe", hif.spi_sdo_oe, 0);
        cs_high();
        check("bad_cmd_no_write", cpu_reset, 0);

        cs_low();
        xfer(8'h80, 5, r);
        cs_high();
        cs_low();
        xfer(8'h0B, 8, r);
        xfer(8'h01, 8, r);
        check("partial_oe", hif.spi_sdo_oe, 0);
        cs_high();
        check("partial_no_write", cpu_reset, 0);

        write_reg(8'h0B, 8'h01);
        cs_low();
        xfer(8'h40, 8, r);
        xfer(8'h03, 8, r);
        xfer(8'h00, 3, r);
        resetb = 1'b0;
        clocks(3);
        check("midrst_oe", hif.spi_sdo_oe, 0);
        check("midrst_sdo", hif.spi_sdo, 0);
        check("midrst_cpu_reset", cpu_reset, 0);
        check("midrst_user_csb", user_flash_csb, 1);
        check("midrst_user_sck", user_flash_sck, 0);
        resetb = 1'b1;
        clocks(3);
        xfer(8'h00, 5, r);
        xfer(8'hFF, 8, r);
        check("midrst_wait_fall", hif.spi_sdo_oe, 0);
        cs_high();
        read_reg(8'h03, r);
        check("post_rst_read", r, 8'h20);
        read_reg(8'h0B, r);
        check("post_rst_reg0b", r, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
